patch_result_serializer: RTL and testbench

Downstream consumer of the 4x4 node patch solver. Captures each completed 4x4 displacement array (u_2 for one time step) when the patch signals end-of-iteration, and holds it in a two-frame buffer. Streams the 16 node values out in raster order over a valid/ready interface to the display/audio path. Tracks per-frame peak magnitude, a frame counter and dropped-frame statistics.

---
 rtl/drum_pkg.sv | 30 +++
 rtl/patch_frame_buffer.sv | 69 ++++++
 rtl/patch_result_serializer.sv | 145 ++++++++++++++
 tb/tb_patch_result_serializer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared types for the 4x4 drum patch: node and patch formats, read-side FSM
// states and the saturating magnitude used for peak tracking.
package drum_pkg;

    localparam int WIDTH = 18;
    localparam int N     = 4;

    typedef logic signed [WIDTH-1:0] node_t;
    typedef node_t [N-1:0][N-1:0]    patch_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } rd_state_e;

    // The most negative node value has no positive twin; clamp it to the max.
    function automatic logic [WIDTH-2:0] abs_sat(input node_t x);
        logic [WIDTH-1:0] neg;
        neg = '0;
        if (x[WIDTH-1]) begin
            if (x[WIDTH-2:0] == '0) begin
                return '1;
            end
            neg = -x;
            return neg[WIDTH-2:0];
        end
        return x[WIDTH-2:0];
    endfunction

endpackage

// File: rtl/patch_frame_buffer.sv
// Two-bank patch store with write/read pointers and occupancy. Captures arriving
// while both banks are full are dropped and counted.
module patch_frame_buffer #(
    parameter int WIDTH  = 18,
    parameter int N      = 4,
    parameter int DROP_W = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             capture_i,
    input  logic                             pop_i,
    input  logic [N-1:0][N-1:0][WIDTH-1:0]   patch_i,
    output logic [N-1:0][N-1:0][WIDTH-1:0]   nxt_patch_o,
    output logic [1:0]                       occ_nxt_o,
    output logic                             overflow_o,
    output logic [DROP_W-1:0]                drop_count_o
);
    import drum_pkg::*;

    logic [N-1:0][N-1:0][WIDTH-1:0] bank_q [2];
    logic              wp_q, wp_d, rp_q, rp_d;
    logic [1:0]        occ_q, occ_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              wr_en, drop;

    always_comb begin
        // A full buffer still takes a capture when the reader frees a bank this cycle.
        wr_en      = capture_i && ((occ_q != 2'd2) || pop_i);
        drop       = capture_i && (occ_q == 2'd2) && !pop_i;
        wp_d       = wp_q ^ wr_en;
        rp_d       = rp_q ^ pop_i;
        occ_d      = occ_q + 2'(wr_en) - 2'(pop_i);
        overflow_d = overflow_q | drop;
        drop_d     = drop_q;
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
        // Bypass so the reader sees a frame in the same edge it is written.
        nxt_patch_o = (wr_en && (wp_q == rp_d)) ? patch_i : bank_q[rp_d];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            occ_q      <= 2'd0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            bank_q[wp_q] <= patch_i;
        end
    end

    assign occ_nxt_o    = occ_d;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;

endmodule

// File: rtl/patch_result_serializer.sv
// Captures solver patches on the falling edge of iter_flag and streams them out
// in raster order over valid/ready, tracking frame count and per-frame peak.
module patch_result_serializer #(
    parameter int WIDTH  = 18,
    parameter int N      = 4,
    parameter int DROP_W = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic signed [N-1:0][N-1:0][WIDTH-1:0] u_2_mid,
    input  logic                                  iter_flag,
    output logic signed [WIDTH-1:0]               out_data,
    output logic [$clog2(N)-1:0]                  out_row,
    output logic [$clog2(N)-1:0]                  out_col,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [15:0]                           frame_count,
    output logic [WIDTH-2:0]                      frame_peak,
    output logic                                  overflow,
    output logic [DROP_W-1:0]                     drop_count
);
    import drum_pkg::*;

    localparam int IW = $clog2(N);

    rd_state_e               state_q, state_d;
    logic                    iter_q;
    logic                    capture, accept, last_acc, load;
    logic [IW-1:0]           row_q, row_d, col_q, col_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    last_q, last_d;
    logic [15:0]             fcnt_q, fcnt_d;
    logic [WIDTH-2:0]        peak_q, peak_d, run_q, run_d, beat_abs, run_max;
    logic [1:0]              occ_nxt;
    logic [N-1:0][N-1:0][WIDTH-1:0] nxt_patch;

    assign capture  = iter_q && !iter_flag;
    assign accept   = (state_q == S_STREAM) && out_ready;
    assign last_acc = accept && (row_q == IW'(N-1)) && (col_q == IW'(N-1));
    assign beat_abs = abs_sat(data_q);
    assign run_max  = (beat_abs > run_q) ? beat_abs : run_q;

    patch_frame_buffer #(
        .WIDTH  (WIDTH),
        .N      (N),
        .DROP_W (DROP_W)
    ) u_buf (
        .clk_i        (clock),
        .rst_ni       (reset),
        .capture_i    (capture),
        .pop_i        (last_acc),
        .patch_i      (u_2_mid),
        .nxt_patch_o  (nxt_patch),
        .occ_nxt_o    (occ_nxt),
        .overflow_o   (overflow),
        .drop_count_o (drop_count)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        last_d  = last_q;
        fcnt_d  = fcnt_q;
        peak_d  = peak_q;
        run_d   = run_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (occ_nxt != 2'd0) begin
                    state_d = S_STREAM;
                    row_d   = '0;
                    col_d   = '0;
                    load    = 1'b1;
                end
            end
            S_STREAM: begin
                if (accept) begin
                    run_d = run_max;
                    load  = 1'b1;
                    if (last_acc) begin
                        row_d  = '0;
                        col_d  = '0;
                        fcnt_d = fcnt_q + 16'd1;
                        peak_d = run_max;
                        run_d  = '0;
                        if (occ_nxt == 2'd0) begin
                            state_d = S_IDLE;
                            load    = 1'b0;
                        end
                    end else if (col_q == IW'(N-1)) begin
                        col_d = '0;
                        row_d = row_q + IW'(1);
                    end else begin
                        col_d = col_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Output beat is registered from the buffer's next-read view.
        if (load) begin
            data_d = nxt_patch[row_d][col_d];
            last_d = (row_d == IW'(N-1)) && (col_d == IW'(N-1));
        end else if (state_d == S_IDLE) begin
            data_d = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            iter_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            fcnt_q  <= '0;
            peak_q  <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_flag;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            last_q  <= last_d;
            fcnt_q  <= fcnt_d;
            peak_q  <= peak_d;
            run_q   <= run_d;
        end
    end

    assign out_valid   = (state_q == S_STREAM);
    assign out_data    = data_q;
    assign out_row     = row_q;
    assign out_col     = col_q;
    assign out_last    = last_q;
    assign frame_count = fcnt_q;
    assign frame_peak  = peak_q;

endmodule

// File: tb/tb_patch_result_serializer.sv
// Directed bench: expected beats are queued when a frame is captured and checked
// as the serializer hands them out.
module tb_patch_result_serializer;

    typedef logic [3:0][3:0][17:0] tpatch_t;
    typedef struct packed {
        logic [17:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } beat_t;

    logic        clock, reset, iter_flag, out_ready;
    tpatch_t     u_2_mid;
    logic [17:0] out_data;
    logic [1:0]  out_row, out_col;
    logic        out_last, out_valid, overflow;
    logic [15:0] frame_count;
    logic [16:0] frame_peak;
    logic [7:0]  drop_count;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;

    patch_result_serializer #(.WIDTH(18), .N(4), .DROP_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .u_2_mid     (u_2_mid),
        .iter_flag   (iter_flag),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_count (frame_count),
        .frame_peak  (frame_peak),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tpatch_t mk(input int base, input int step);
        tpatch_t p;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                p[r][c] = 18'(base + step * (r * 4 + c));
        return p;
    endfunction

    task automatic push_frame(input tpatch_t p);
        beat_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                b.d = p[r][c];
                b.r = 2'(r);
                b.c = 2'(c);
                b.l = (r == 3) && (c == 3);
                q.push_back(b);
            end
    endtask

    // Two-cycle iter_flag pulse; returns 1 time unit after the capture edge.
    task automatic cap(input tpatch_t p, input bit expect_accept);
        u_2_mid   = p;
        iter_flag = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        iter_flag = 1'b0;
        if (expect_accept) push_frame(p);
        @(posedge clock); #1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && q.size() != 0; i++) @(posedge clock);
        #1;
        check("drain_empty", q.size(), 0);
        @(posedge clock); #1;
    endtask

    // Beat monitor: scoreboard compare on accepted beats, hold check on stalls.
    initial begin : monitor
        beat_t e;
        logic        stall;
        logic [17:0] s_d;
        logic [1:0]  s_r, s_c;
        logic        s_l;
        stall = 1'b0;
        s_d = '0; s_r = '0; s_c = '0; s_l = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, s_d);
                check("stall_row", out_row, s_r);
                check("stall_col", out_col, s_c);
                check("stall_last", out_last, s_l);
            end
            if (out_valid && out_ready) begin
                check("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("beat_data", out_data, e.d);
                    check("beat_row", out_row, e.r);
                    check("beat_col", out_col, e.c);
                    check("beat_last", out_last, e.l);
                end
            end
            stall = out_valid && !out_ready;
            s_d = out_data; s_r = out_row; s_c = out_col; s_l = out_last;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        tpatch_t p, pf;
        int      bubbles;
        bit      found;

        reset = 1'b0; iter_flag = 1'b0; out_ready = 1'b0; u_2_mid = '0;
        @(posedge clock); @(posedge clock); #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        check("rst_last", out_last, 0);
        check("rst_fcnt", frame_count, 0);
        check("rst_peak", frame_peak, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_count, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Single frame, value r*4+c, ready held high.
        out_ready = 1'b1;
        p = mk(0, 1);
        cap(p, 1);
        check("lat_valid", out_valid, 1);
        check("lat_row", out_row, 0);
        check("lat_col", out_col, 0);
        drain(40);
        check("f1_fcnt", frame_count, 1);
        check("f1_peak", frame_peak, 15);
        check("f1_idle", out_valid, 0);

        // Backpressure: ready toggles every cycle.
        out_ready = 1'b0;
        cap(mk(-20, 3), 1);
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(posedge clock); #1;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        drain(10);
        check("bp_fcnt", frame_count, 2);
        check("bp_peak", frame_peak, 25);

        // Overflow: three captures into a stalled two-bank buffer.
        out_ready = 1'b0;
        cap(mk(1000, 1), 1);
        cap(mk(-2000, -1), 1);
        cap(mk(500, 2), 0);
        check("ovf_flag", overflow, 1);
        check("ovf_drop", drop_count, 1);
        check("ovf_valid", out_valid, 1);
        check("ovf_head", out_data, 18'(1000));
        out_ready = 1'b1;
        drain(80);
        repeat (5) @(posedge clock);
        #1;
        check("ovf_idle", out_valid, 0);
        check("ovf_fcnt", frame_count, 4);
        check("ovf_peak", frame_peak, 2015);

        // Capture on the same edge as the last accepted beat with both banks full.
        out_ready = 1'b0;
        cap(mk(10, 1), 1);
        cap(mk(-10, -1), 1);
        pf = mk(0, 11);
        u_2_mid = pf;
        out_ready = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clock); #1;
            if (k == 13) iter_flag = 1'b1;
            if (k == 15) begin
                iter_flag = 1'b0;
                push_frame(pf);
            end
        end
        @(posedge clock);
        bubbles = 0;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (!out_valid) bubbles++;
            @(posedge clock);
        end
        #1;
        check("sim_bubbles", bubbles, 0);
        check("sim_drop", drop_count, 1);
        drain(40);
        check("sim_fcnt", frame_count, 7);
        check("sim_peak", frame_peak, 165);

        // Magnitude saturation of the most negative node.
        p = '0;
        p[1][2] = 18'h20000;
        p[3][0] = 18'd5;
        cap(p, 1);
        drain(40);
        check("sat_peak", frame_peak, 17'h1FFFF);
        check("sat_fcnt", frame_count, 8);

        // Drop counter saturation.
        out_ready = 1'b0;
        cap(mk(1, 1), 1);
        cap(mk(2, 1), 1);
        for (int i = 0; i < 256; i++) cap(mk(3, 1), 0);
        check("dsat_drop", drop_count, 255);
        check("dsat_ovf", overflow, 1);
        out_ready = 1'b1;
        drain(80);
        check("dsat_fcnt", frame_count, 10);

        // Reset while beat 7 is on the output.
        cap(mk(3, 7), 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (out_valid && out_row == 2'd1 && out_col == 2'd3) found = 1'b1;
        end
        check("mid_found", found, 1);
        #1 reset = 1'b0;
        #1;
        q.delete();
        check("mid_valid", out_valid, 0);
        check("mid_data", out_data, 0);
        check("mid_row", out_row, 0);
        check("mid_col", out_col, 0);
        check("mid_last", out_last, 0);
        check("mid_fcnt", frame_count, 0);
        check("mid_peak", frame_peak, 0);
        check("mid_ovf", overflow, 0);
        check("mid_drop", drop_count, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("post_idle", out_valid, 0);
        p = mk(-50, 4);
        cap(p, 1);
        check("post_valid", out_valid, 1);
        check("post_row", out_row, 0);
        check("post_col", out_col, 0);
        check("post_data", out_data, p[0][0]);
        drain(40);
        check("post_fcnt", frame_count, 1);
        check("post_peak", frame_peak, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
